// File: rtl/cpu_pkg.sv
// Shared data-cache definitions: geometry, FSM encoding and a byte-select helper.
package cpu_pkg;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned TAG_W       = 3;
    localparam int unsigned INDEX_W     = 3;
    localparam int unsigned OFFSET_W    = 2;
    localparam int unsigned NUM_BLOCKS  = 8;
    localparam int unsigned MEM_BLOCK_W = 32;
    localparam int unsigned MEM_ADDR_W  = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StFetch     = 2'd2,
        StUpdate    = 2'd3
    } dcache_state_t;

    function automatic logic [DATA_W-1:0] sel_byte(input logic [MEM_BLOCK_W-1:0] line,
                                                   input logic [OFFSET_W-1:0]    off);
        return line[{off, 3'b000} +: DATA_W];
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side load/store bus of the data cache.
interface data_cache_if;
    import cpu_pkg::*;

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (output read, write, address, writedata, input readdata, busywait);
    modport slave  (input read, write, address, writedata, output readdata, busywait);

endinterface

// File: rtl/dcache_line_array.sv
// Line storage: data and tags without reset, valid/dirty cleared asynchronously.
module dcache_line_array
    import cpu_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INDEX_W-1:0]     rd_idx_i,
    output logic [MEM_BLOCK_W-1:0] rd_line_o,
    output logic [TAG_W-1:0]       rd_tag_o,
    output logic                   rd_valid_o,
    output logic                   rd_dirty_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_W-1:0]     wr_idx_i,
    input  logic [OFFSET_W-1:0]    wr_off_i,
    input  logic [DATA_W-1:0]      wr_byte_i,
    input  logic                   fill_en_i,
    input  logic [INDEX_W-1:0]     fill_idx_i,
    input  logic [TAG_W-1:0]       fill_tag_i,
    input  logic [MEM_BLOCK_W-1:0] fill_line_i
);

    logic [MEM_BLOCK_W-1:0] data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [NUM_BLOCKS-1:0]  dirty_q;

    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            data_q[fill_idx_i] <= fill_line_i;
            tag_q[fill_idx_i]  <= fill_tag_i;
        end else if (wr_en_i) begin
            data_q[wr_idx_i][{wr_off_i, 3'b000} +: DATA_W] <= wr_byte_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx_i] <= 1'b1;
            dirty_q[fill_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

    assign rd_line_o  = data_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache: hit compare, miss FSM and 32-bit memory interface.
// Define DCACHE_STATS_EN to add saturating hit_count_o / miss_count_o outputs.
module data_cache
    import cpu_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    data_cache_if.slave            cpu_if,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [MEM_ADDR_W-1:0]  mem_address_o,
    output logic [MEM_BLOCK_W-1:0] mem_writedata_o,
    input  logic [MEM_BLOCK_W-1:0] mem_readdata_i,
    input  logic                   mem_busywait_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]            hit_count_o,
    output logic [15:0]            miss_count_o
`endif
);

    dcache_state_t          state_q, state_d;
    logic                   mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [MEM_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [MEM_BLOCK_W-1:0] mem_wdata_q, mem_wdata_d, fill_q, fill_d;
    logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0]     miss_idx_q, miss_idx_d;
    logic [DATA_W-1:0]      readdata_q, readdata_d;

    logic [TAG_W-1:0]       tag;
    logic [INDEX_W-1:0]     idx;
    logic [OFFSET_W-1:0]    off;
    logic [MEM_BLOCK_W-1:0] line_data;
    logic [TAG_W-1:0]       line_tag;
    logic                   line_valid, line_dirty;
    logic                   req, hit, busy, wr_en, fill_en;

    assign {tag, idx, off} = cpu_if.address;
    assign req = cpu_if.read | cpu_if.write;
    assign hit = line_valid & (line_tag == tag);

    dcache_line_array u_lines (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (idx),
        .rd_line_o   (line_data),
        .rd_tag_o    (line_tag),
        .rd_valid_o  (line_valid),
        .rd_dirty_o  (line_dirty),
        .wr_en_i     (wr_en),
        .wr_idx_i    (idx),
        .wr_off_i    (off),
        .wr_byte_i   (cpu_if.writedata),
        .fill_en_i   (fill_en),
        .fill_idx_i  (miss_idx_q),
        .fill_tag_i  (miss_tag_q),
        .fill_line_i (fill_q)
    );

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        fill_d      = fill_q;
        readdata_d  = readdata_q;
        busy        = 1'b0;
        wr_en       = 1'b0;
        fill_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    // A simultaneous read+write is serviced as a store only.
                    if (cpu_if.write) wr_en = 1'b1;
                    else readdata_d = sel_byte(line_data, off);
                end else if (req) begin
                    busy       = 1'b1;
                    miss_tag_d = tag;
                    miss_idx_d = idx;
                    if (line_dirty) begin
                        state_d     = StWriteback;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {line_tag, idx};
                        mem_wdata_d = line_data;
                    end else begin
                        state_d    = StFetch;
                        mem_read_d = 1'b1;
                        mem_addr_d = {tag, idx};
                    end
                end
            end
            StWriteback: begin
                busy = 1'b1;
                if (!mem_busywait_i) begin
                    state_d     = StFetch;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {miss_tag_q, miss_idx_q};
                end
            end
            StFetch: begin
                busy = 1'b1;
                if (!mem_busywait_i) begin
                    state_d    = StUpdate;
                    mem_read_d = 1'b0;
                    fill_d     = mem_readdata_i;
                end
            end
            StUpdate: begin
                busy    = 1'b1;
                fill_en = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
            fill_q      <= '0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
            fill_q      <= fill_d;
            readdata_q  <= readdata_d;
        end
    end

    // Gated by reset so a request still held during reset cannot raise the stall.
    assign cpu_if.busywait = busy & ~rst_i;
    assign cpu_if.readdata = readdata_d;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_address_o   = mem_addr_q;
    assign mem_writedata_o = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        retry_q;

    // retry_q marks the post-fill re-probe so it is not counted as a hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            retry_q <= (state_q == StUpdate);
            if (state_q == StIdle && req && hit && !retry_q && hit_cnt_q != 16'hFFFF)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (state_q == StIdle && req && !hit && miss_cnt_q != 16'hFFFF)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a fixed-latency block-memory model.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read, mem_write, mem_busywait = 1'b0;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem_blk [64];
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    typedef struct {logic wr; logic [5:0] addr; logic [31:0] data;} ev_t;
    ev_t ev_q[$];

    int          chk = 0;
    int          pass = 0;
    int          both_hi = 0;
    int          lat_cnt = 0;
    logic [1:0]  cur, req_prev = 2'b00;

    data_cache_if cpu_if ();

    data_cache dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cpu_if          (cpu_if),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_address_o   (mem_addr),
        .mem_writedata_o (mem_wdata),
        .mem_readdata_i  (mem_rdata),
        .mem_busywait_i  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o     (hit_cnt),
        .miss_count_o    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_blk[mem_addr];

    // Memory: busy for two sampling edges after each new request, then completes.
    always @(negedge clk) begin
        cur = {mem_read, mem_write};
        if (cur == 2'b11) both_hi++;
        if (cur != req_prev) lat_cnt = 2;
        else if (lat_cnt != 0) lat_cnt--;
        req_prev = cur;
        mem_busywait = (cur != 2'b00) && (lat_cnt != 0);
        if (cur != 2'b00 && !mem_busywait) begin
            ev_q.push_back('{wr: mem_write, addr: mem_addr, data: mem_wdata});
            if (mem_write) mem_blk[mem_addr] = mem_wdata;
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] wd, output int stall, output logic [7:0] rdata);
        @(negedge clk);
        cpu_if.read = rd; cpu_if.write = wr; cpu_if.address = a; cpu_if.writedata = wd;
        #1;
        stall = 0;
        while (cpu_if.busywait && stall < 100) begin
            @(negedge clk); #1;
            stall++;
        end
        rdata = cpu_if.readdata;
        chk++;
        if (stall >= 100) $display("FAIL access_timeout: addr %h still stalled after %0d cycles", a, stall);
        else pass++;
        @(posedge clk); #1;
        cpu_if.read = 1'b0; cpu_if.write = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        chk++; if (cpu_if.busywait !== 1'b0) $display("FAIL reset_busywait: got %b want 0", cpu_if.busywait); else pass++;
        chk++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b want 0", mem_read); else pass++;
        chk++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b want 0", mem_write); else pass++;
        chk++; if (cpu_if.readdata !== 8'h00) $display("FAIL reset_readdata: got %h want 00", cpu_if.readdata); else pass++;
        chk++; if (mem_addr !== 6'h00) $display("FAIL reset_mem_address: got %h want 00", mem_addr); else pass++;
        chk++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_writedata: got %h want 0", mem_wdata); else pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_cold_read();
        int st; logic [7:0] rd;
        ev_q.delete();
        do_access(1'b1, 1'b0, 8'h25, 8'h00, st, rd);
        chk++; if (st == 0) $display("FAIL cold_stall: got %0d cycles want >0", st); else pass++;
        chk++;
        if (ev_q.size() != 1 || ev_q[0].wr !== 1'b0 || ev_q[0].addr !== 6'h09)
            $display("FAIL cold_mem_read: got %0d transfers want one read of 09", ev_q.size());
        else pass++;
        chk++; if (rd !== 8'hBB) $display("FAIL cold_readdata: got %h want BB", rd); else pass++;
    endtask

    task automatic test_read_hit();
        int st; logic [7:0] rd;
        ev_q.delete();
        do_access(1'b1, 1'b0, 8'h27, 8'h00, st, rd);
        chk++; if (st != 0) $display("FAIL hit_stall: got %0d want 0", st); else pass++;
        chk++; if (rd !== 8'hDD) $display("FAIL hit_readdata: got %h want DD", rd); else pass++;
        chk++; if (ev_q.size() != 0) $display("FAIL hit_mem_idle: got %0d transfers want 0", ev_q.size()); else pass++;
    endtask

    task automatic test_write_evict();
        int st; logic [7:0] rd;
        ev_q.delete();
        do_access(1'b0, 1'b1, 8'h25, 8'h5A, st, rd);
        chk++; if (st != 0 || ev_q.size() != 0) $display("FAIL whit_stall: got %0d cycles %0d transfers want 0 0", st, ev_q.size()); else pass++;
        do_access(1'b1, 1'b0, 8'h45, 8'h00, st, rd);
        chk++;
        if (ev_q.size() != 2 || ev_q[0].wr !== 1'b1 || ev_q[0].addr !== 6'h09 || ev_q[0].data !== 32'hDDCC5AAA)
            $display("FAIL evict_writeback: got %0d transfers want write 09 DDCC5AAA first", ev_q.size());
        else pass++;
        chk++;
        if (ev_q.size() != 2 || ev_q[1].wr !== 1'b0 || ev_q[1].addr !== 6'h11)
            $display("FAIL evict_fetch: got %0d transfers want read 11 second", ev_q.size());
        else pass++;
        chk++; if (rd !== 8'h22) $display("FAIL evict_readdata: got %h want 22", rd); else pass++;
    endtask

    task automatic test_write_miss();
        int st; logic [7:0] rd;
        ev_q.delete();
        do_access(1'b0, 1'b1, 8'hE0, 8'h11, st, rd);
        chk++;
        if (st == 0 || ev_q.size() != 1 || ev_q[0].wr !== 1'b0 || ev_q[0].addr !== 6'h38)
            $display("FAIL wmiss_fetch: got %0d cycles %0d transfers want stall and one read of 38", st, ev_q.size());
        else pass++;
        ev_q.delete();
        do_access(1'b1, 1'b0, 8'h00, 8'h00, st, rd);
        chk++;
        if (ev_q.size() != 2 || ev_q[0].wr !== 1'b1 || ev_q[0].addr !== 6'h38 || ev_q[0].data !== 32'h87654311)
            $display("FAIL wmiss_dirty_wb: got %0d transfers want write 38 87654311 first", ev_q.size());
        else pass++;
        chk++; if (rd !== 8'h00) $display("FAIL wmiss_readdata: got %h want 00", rd); else pass++;
    endtask

    task automatic test_reset_mid_fetch();
        int st; int n; logic [7:0] rd;
        @(negedge clk);
        cpu_if.read = 1'b1; cpu_if.address = 8'h84;
        n = 0;
        while (mem_read !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk++; if (n >= 20) $display("FAIL rst_fetch_start: mem_read %b want 1", mem_read); else pass++;
        #1 rst = 1'b1;
        #1;
        chk++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read: got %b want 0", mem_read); else pass++;
        chk++; if (cpu_if.busywait !== 1'b0) $display("FAIL rst_busywait: got %b want 0", cpu_if.busywait); else pass++;
        cpu_if.read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ev_q.delete();
        do_access(1'b1, 1'b0, 8'h84, 8'h00, st, rd);
        chk++;
        if (st == 0 || ev_q.size() != 1 || ev_q[0].wr !== 1'b0 || ev_q[0].addr !== 6'h21)
            $display("FAIL rst_remiss: got %0d cycles %0d transfers want stall and read of 21", st, ev_q.size());
        else pass++;
        chk++; if (rd !== 8'h21) $display("FAIL rst_readdata: got %h want 21", rd); else pass++;
    endtask

    task automatic test_read_write_hit();
        int st; logic [7:0] rd;
`ifdef DCACHE_STATS_EN
        logic [15:0] h0;
        h0 = hit_cnt;
`endif
        ev_q.delete();
        do_access(1'b1, 1'b1, 8'h85, 8'h77, st, rd);
        chk++; if (st != 0 || ev_q.size() != 0) $display("FAIL rw_stall: got %0d cycles %0d transfers want 0 0", st, ev_q.size()); else pass++;
        chk++; if (rd !== 8'h21) $display("FAIL rw_readdata_hold: got %h want 21", rd); else pass++;
`ifdef DCACHE_STATS_EN
        chk++; if (hit_cnt !== h0 + 16'd1) $display("FAIL rw_hit_count: got %0d want %0d", hit_cnt, h0 + 16'd1); else pass++;
`endif
        do_access(1'b1, 1'b0, 8'h25, 8'h00, st, rd);
        chk++;
        if (ev_q.size() != 2 || ev_q[0].wr !== 1'b1 || ev_q[0].addr !== 6'h21 || ev_q[0].data !== 32'h21217721)
            $display("FAIL rw_dirty_wb: got %0d transfers want write 21 21217721 first", ev_q.size());
        else pass++;
        chk++; if (rd !== 8'h5A) $display("FAIL rw_refetch: got %h want 5A", rd); else pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_blk[i] = 32'h01010101 * i;
        mem_blk[6'h09] = 32'hDDCCBBAA;
        mem_blk[6'h11] = 32'h44332211;
        mem_blk[6'h38] = 32'h87654321;
        cpu_if.read = 1'b0; cpu_if.write = 1'b0; cpu_if.address = 8'h00; cpu_if.writedata = 8'h00;
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_evict();
        test_write_miss();
        test_reset_mid_fetch();
        test_read_write_hit();
        chk++; if (both_hi != 0) $display("FAIL mem_rd_wr_exclusive: got %0d overlaps want 0", both_hi); else pass++;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
